// File: rtl/seg7_pkg.sv
// Shared constants and decode helper for the multiplexed 7-segment display driver.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'b000_1110,  // F
    7'b000_0110,  // E
    7'b010_0001,  // d
    7'b100_0110,  // C
    7'b000_0011,  // b
    7'b000_1000,  // A
    7'b001_0000,  // 9
    7'b000_0000,  // 8
    7'b111_1000,  // 7
    7'b000_0010,  // 6
    7'b001_0010,  // 5
    7'b001_1001,  // 4
    7'b011_0000,  // 3
    7'b010_0100,  // 2
    7'b111_1001,  // 1
    7'b100_0000   // 0
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib, input logic hex_en);
    logic [6:0] seg;
    if (!hex_en && (nib > 4'd9)) begin
      seg = SEG_BLANK;
    end else begin
      seg = SEG7_TABLE[nib];
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment decoder; letters A-F only when HEX_EN is set.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int unsigned HEX_EN = 1
) (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_decode(nib_i, (HEX_EN != 0));

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered frame data,
// per-digit blank/dp, optional leading-zero suppression and anode dead time.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEAD_CYC   = 16,
  parameter int unsigned HEX_EN     = 1,
  parameter int unsigned LZ_BLANK   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   iData,
  input  logic [NUM_DIGITS-1:0]     iDp,
  input  logic [NUM_DIGITS-1:0]     iBlank,
  input  logic                      iLoad,
  output logic [6:0]                oSeg,
  output logic                      oDp,
  output logic [NUM_DIGITS-1:0]     oAn,
  output logic                      oFrame
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_V   = DIV_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]                div_q, div_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      stg_data_q;
  logic [NUM_DIGITS-1:0]           stg_dp_q, stg_blank_q;
  logic                            pend_q, pend_d;
  logic [NUM_DIGITS-1:0][3:0]      sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d, frame_q, frame_d;
  logic                            boundary_s, dark_s;
  logic [NUM_DIGITS-1:0]           lz_zero_s;
  logic [6:0]                      dec_seg_s;

  assign boundary_s = (div_q == DIV_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    div_d      = div_q + 1'b1;
    idx_d      = idx_q;
    pend_d     = pend_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      idx_d = idx_q;
    end
    // A load landing on the boundary bypasses staging so the next frame already shows it.
    if (boundary_s) begin
      pend_d = 1'b0;
      if (iLoad) begin
        sh_data_d  = iData;
        sh_dp_d    = iDp;
        sh_blank_d = iBlank;
      end else if (pend_q) begin
        sh_data_d  = stg_data_q;
        sh_dp_d    = stg_dp_q;
        sh_blank_d = stg_blank_q;
      end else begin
        sh_data_d  = sh_data_q;
      end
    end else if (iLoad) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // lz_zero_s[k] is set when digit k and every more significant digit hold zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lz_zero_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run & (sh_data_d[k] == 4'h0);
      lz_zero_s[k] = run;
    end
  end

  seg7_hex_decode #(.HEX_EN(HEX_EN)) u_dec (
    .nib_i (sh_data_d[idx_d]),
    .seg_o (dec_seg_s)
  );

  always_comb begin
    dark_s  = sh_blank_d[idx_d] | ((LZ_BLANK != 0) && (idx_d != '0) && lz_zero_s[idx_d]);
    seg_d   = dark_s ? SEG_BLANK : dec_seg_s;
    dp_d    = sh_blank_d[idx_d] ? 1'b1 : ~sh_dp_d[idx_d];
    frame_d = boundary_s;
    an_d    = '1;
    if (div_d < DEAD_V) begin
      an_d = '1;
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_d != IDX_W'(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      stg_data_q  <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      pend_q      <= 1'b0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '1;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
      if (iLoad) begin
        stg_data_q  <= iData;
        stg_dp_q    <= iDp;
        stg_blank_q <= iBlank;
      end else begin
        stg_data_q  <= stg_data_q;
      end
    end
  end

  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oAn    = an_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized and directed bench for seg7_scan_display with a frame-level behavioural model;
// instance a is hex/no-LZ, instance b is decimal-only with leading-zero suppression.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp, blank;
  logic        load;
  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_frame, b_frame;
  logic [3:0]  a_an, b_an;

  int total = 0;
  int bad   = 0;

  int          t;
  logic [15:0] m_data, l_data;
  logic [3:0]  m_dp, m_blank, l_dp, l_blank;
  bit          have_new, in_reset;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .HEX_EN(1), .LZ_BLANK(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .iData(data), .iDp(dp), .iBlank(blank), .iLoad(load),
    .oSeg(a_seg), .oDp(a_dp), .oAn(a_an), .oFrame(a_frame));

  seg7_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .HEX_EN(0), .LZ_BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .iData(data), .iDp(dp), .iBlank(blank), .iLoad(load),
    .oSeg(b_seg), .oDp(b_dp), .oAn(b_an), .oFrame(b_frame));

  function automatic int cur_ix();
    return (t / SD) % ND;
  endfunction

  function automatic logic [6:0] exp_seg(bit hex, bit lz);
    int ix;
    logic [3:0] nib;
    ix  = cur_ix();
    nib = m_data[4*ix +: 4];
    if (m_blank[ix]) return 7'h7F;
    if (lz && ix > 0 && ((m_data >> (4*ix)) == 16'h0)) return 7'h7F;
    if (!hex && nib > 4'd9) return 7'h7F;
    return seg_tab[nib];
  endfunction

  function automatic logic exp_dp();
    return m_blank[cur_ix()] ? 1'b1 : ~m_dp[cur_ix()];
  endfunction

  function automatic logic [3:0] exp_an();
    if ((t % SD) < DC) return 4'hF;
    return ~(4'b0001 << cur_ix());
  endfunction

  function automatic logic exp_frame();
    return (t > 0) && ((t % FR) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic check_all();
    chk("a_an", a_an, exp_an());
    chk("a_seg", a_seg, exp_seg(1'b1, 1'b0));
    chk("a_dp", a_dp, exp_dp());
    chk("a_frame", a_frame, exp_frame());
    chk("b_an", b_an, exp_an());
    chk("b_seg", b_seg, exp_seg(1'b0, 1'b1));
    chk("b_dp", b_dp, exp_dp());
    chk("b_frame", b_frame, exp_frame());
  endtask

  task automatic model_reset();
    t = 0;
    m_data = 16'h0; m_dp = 4'h0; m_blank = 4'hF;
    l_data = 16'h0; l_dp = 4'h0; l_blank = 4'hF;
    have_new = 1'b0;
  endtask

  task automatic model_edge();
    if (load) begin
      l_data = data; l_dp = dp; l_blank = blank;
      have_new = 1'b1;
    end
    if ((t % FR) == FR - 1) begin
      if (have_new) begin
        m_data = l_data; m_dp = l_dp; m_blank = l_blank;
      end
      have_new = 1'b0;
    end
    t++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!in_reset) model_edge();
    #1;
    check_all();
    load = 1'b0;
  endtask

  task automatic go_phase(input int p);
    do cycle(); while ((t % FR) != p);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst_n = 1'b1; load = 1'b0; data = 16'h0; dp = 4'h0; blank = 4'h0;
    in_reset = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_an", a_an, 4'b1111);
    chk("reset_seg", a_seg, 7'h7F);
    chk("reset_dp", a_dp, 1'b1);
    chk("reset_frame", a_frame, 1'b0);
    check_all();
    repeat (3) cycle();
    rst_n = 1'b0;
    in_reset = 1'b0;
    rst_n = 1'b1;
    repeat (20) cycle();
    chk("dark_no_load", a_seg, 7'h7F);

    // Frame display of 3A10 with dp on digit 2
    do_load(16'h3A10, 4'b0100, 4'b0000);
    go_phase(0);
    chk("frame_pulse", a_frame, 1'b1);
    chk("dead_an", a_an, 4'b1111);
    chk("dead_seg", a_seg, 7'b1000000);
    go_phase(1);
    chk("d0_an", a_an, 4'b1110); chk("d0_seg", a_seg, 7'b1000000);
    go_phase(5);
    chk("d1_an", a_an, 4'b1101); chk("d1_seg", a_seg, 7'b1111001);
    go_phase(9);
    chk("d2_an", a_an, 4'b1011); chk("d2_seg", a_seg, 7'b0001000); chk("d2_dp", a_dp, 1'b0);
    go_phase(13);
    chk("d3_an", a_an, 4'b0111); chk("d3_seg", a_seg, 7'b0110000); chk("d3_dp", a_dp, 1'b1);
    go_phase(0);
    n = 0;
    repeat (FR) begin
      cycle();
      if (a_frame) n++;
    end
    chk("frame_period", n, 1);

    // Mid-frame load must not tear the current frame
    go_phase(5);
    do_load(16'h5555, 4'b0000, 4'b0000);
    go_phase(9);
    chk("no_tear_seg", a_seg, 7'b0001000);
    go_phase(1);
    chk("next_frame_5", a_seg, 7'b0010010);

    // Load on the boundary cycle, then last-of-two loads wins
    go_phase(FR - 1);
    do_load(16'h1234, 4'b0000, 4'b0000);
    go_phase(1);
    chk("boundary_load", a_seg, 7'b0011001);
    go_phase(3);
    do_load(16'h1111, 4'b0000, 4'b0000);
    go_phase(7);
    do_load(16'h2222, 4'b0000, 4'b0000);
    go_phase(1);
    chk("last_load_wins", a_seg, 7'b0100100);

    // Leading-zero suppression and HEX_EN=0 on instance b
    do_load(16'h0070, 4'b0000, 4'b0000);
    go_phase(1);  chk("lz_d0", b_seg, 7'b1000000);
    go_phase(5);  chk("lz_d1", b_seg, 7'b1111000);
    go_phase(9);  chk("lz_d2", b_seg, 7'h7F); chk("lz_d2_an", b_an, 4'b1011);
    go_phase(13); chk("lz_d3", b_seg, 7'h7F); chk("nolz_d3", a_seg, 7'b1000000);
    do_load(16'h0000, 4'b0000, 4'b0000);
    go_phase(1);  chk("lz0_d0", b_seg, 7'b1000000);
    go_phase(5);  chk("lz0_d1", b_seg, 7'h7F);
    do_load(16'h000C, 4'b0000, 4'b0000);
    go_phase(1);
    chk("nohex_C", b_seg, 7'h7F);
    chk("hex_C", a_seg, 7'b1000110);

    // Randomized loads, data, dp and blank
    repeat (800) begin
      data  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) data = data >> (4 * $urandom_range(1, 4));
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load  = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of digit 2's slot
    do_load(16'h4321, 4'b0000, 4'b0000);
    go_phase(0);
    go_phase(9);
    chk("pre_rst_an", a_an, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", a_an, 4'b1111);
    chk("async_seg", a_seg, 7'h7F);
    chk("async_dp", a_dp, 1'b1);
    chk("async_frame", a_frame, 1'b0);
    in_reset = 1'b1;
    model_reset();
    repeat (2) cycle();
    in_reset = 1'b0;
    rst_n = 1'b1;
    cycle();
    chk("restart_an", a_an, 4'b1110);
    repeat (40) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
